// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory request/acknowledge port between the fetch unit and memory.
interface fetch_pc_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    // Fetch unit drives the request; memory returns ack and data.
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch controller: owns the PC, issues imem requests, loads IF/ID,
// applies ID-stage redirects and absorbs hazard stalls through a one-entry skid buffer.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pc_sel_i,
    input  logic [31:0]            branch_target_i,
    input  logic                   jump_sel_i,
    input  logic [31:0]            jump_target_i,
    input  logic                   stall_i,
    fetch_pc_unit_if.master        imem,
    output logic [31:0]            if_instr_o,
    output logic [31:0]            if_pc4_o,
    output logic                   if_valid_o
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_DISCARD = 2'd2,
        ST_HOLD    = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   req_addr_q, req_addr_d;
    logic [XLEN-1:0]   skid_instr_q, skid_instr_d;
    logic [XLEN-1:0]   skid_pc4_q, skid_pc4_d;
    logic [XLEN-1:0]   if_instr_q, if_instr_d;
    logic [XLEN-1:0]   if_pc4_q, if_pc4_d;
    logic              if_valid_q, if_valid_d;
    logic              req_q, req_d;

    logic              redir;
    logic [XLEN-1:0]   target;
    logic [XLEN-1:0]   pc_plus4;

    // Redirects are ignored while the hazard unit stalls; a taken branch beats a jump.
    assign redir    = (pc_sel_i | jump_sel_i) & ~stall_i;
    assign target   = pc_sel_i ? branch_target_i : jump_target_i;
    assign pc_plus4 = pc_q + XLEN'(4);

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = req_addr_q;
    assign if_instr_o     = if_instr_q;
    assign if_pc4_o       = if_pc4_q;
    assign if_valid_o     = if_valid_q;

    // Next-state, PC, request address, skid and IF/ID update.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_addr_d   = req_addr_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;
        if_instr_d   = if_instr_q;
        if_pc4_d     = if_pc4_q;
        if_valid_d   = if_valid_q;

        case (state_q)
            ST_IDLE: begin
                req_addr_d = pc_q;
                state_d    = ST_FETCH;
            end
            ST_FETCH: begin
                if (redir) begin
                    pc_d       = target;
                    if_instr_d = NOP;
                    if_pc4_d   = '0;
                    if_valid_d = 1'b0;
                    if (imem.imem_ack) begin
                        req_addr_d = target;
                    end else begin
                        // Outstanding request must complete at its old address.
                        state_d = ST_DISCARD;
                    end
                end else if (imem.imem_ack && stall_i) begin
                    skid_instr_d = imem.imem_rdata;
                    skid_pc4_d   = pc_plus4;
                    state_d      = ST_HOLD;
                end else if (imem.imem_ack) begin
                    if_instr_d = imem.imem_rdata;
                    if_pc4_d   = pc_plus4;
                    if_valid_d = 1'b1;
                    pc_d       = pc_plus4;
                    req_addr_d = pc_plus4;
                end else if (!stall_i) begin
                    if_instr_d = NOP;
                    if_pc4_d   = '0;
                    if_valid_d = 1'b0;
                end
            end
            ST_DISCARD: begin
                if (redir) begin
                    pc_d = target;
                end
                if (imem.imem_ack) begin
                    req_addr_d = pc_d;
                    state_d    = ST_FETCH;
                end
                if (!stall_i) begin
                    if_instr_d = NOP;
                    if_pc4_d   = '0;
                    if_valid_d = 1'b0;
                end
            end
            ST_HOLD: begin
                if (!stall_i) begin
                    state_d = ST_FETCH;
                    if (redir) begin
                        pc_d       = target;
                        req_addr_d = target;
                        if_instr_d = NOP;
                        if_pc4_d   = '0;
                        if_valid_d = 1'b0;
                    end else begin
                        if_instr_d = skid_instr_q;
                        if_pc4_d   = skid_pc4_q;
                        if_valid_d = 1'b1;
                        pc_d       = skid_pc4_q;
                        req_addr_d = skid_pc4_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        req_d = (state_d == ST_FETCH) || (state_d == ST_DISCARD);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            req_addr_q   <= RESET_PC;
            skid_instr_q <= '0;
            skid_pc4_q   <= '0;
            if_instr_q   <= NOP;
            if_pc4_q     <= '0;
            if_valid_q   <= 1'b0;
            req_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
            if_instr_q   <= if_instr_d;
            if_pc4_q     <= if_pc4_d;
            if_valid_q   <= if_valid_d;
            req_q        <= req_d;
        end
    end

endmodule
